// File: rtl/mem_io_responder_if.sv
// CPU byte-wide memory bus between the CPU (master) and the memory/IO target (slave).
//  mem_a          CPU byte address
//  mem_wr         1 = write, 0 = read
//  mem_dout       CPU write data
//  mem_din        read data, valid the cycle after the request
//  io_buffer_full TX FIFO nearly full; the CPU must not issue I/O writes
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (
        output mem_a,
        output mem_wr,
        output mem_dout,
        input  mem_din,
        input  io_buffer_full
    );

    modport slave (
        input  mem_a,
        input  mem_wr,
        input  mem_dout,
        output mem_din,
        output io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder.sv
// Target side of the CPU byte-wide memory bus: byte RAM plus the I/O window at 0x30000.
// Reads return data one cycle after the request, writes complete in one cycle.
// UART TX/RX bytes are buffered in FIFOs; a free-running cycle counter and a sticky
// program-stop flag are exposed through the I/O window.
//  clk_in        clock
//  rst_in        synchronous reset, active-low
//  rdy_in        CPU-side enable; 0 freezes bus-side state (TX drain / RX push continue)
//  bus           CPU bus (slave modport): mem_a, mem_wr, mem_dout, mem_din, io_buffer_full
//  tx_data       head of TX FIFO (0x00 while empty)
//  tx_valid      TX FIFO non-empty
//  tx_ready      UART consumes the head when tx_valid & tx_ready
//  rx_data       UART received byte
//  rx_valid      push rx_data when rx_ready
//  rx_ready      RX FIFO not full
//  program_stop  sticky; set by a write to 0x30004
//  tx_overflow   sticky; a TX push hit a full FIFO
module mem_io_responder #(
    parameter int RAM_AW = 17,
    parameter int TX_LOG = 4,
    parameter int RX_LOG = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    mem_io_responder_if.slave   bus,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                program_stop,
    output logic                tx_overflow
);

    localparam int TCW = TX_LOG + 1;
    localparam int RCW = RX_LOG + 1;
    localparam logic [TCW-1:0] TX_FULL = {1'b1, {TX_LOG{1'b0}}};
    localparam logic [TCW-1:0] TX_NEAR = TX_FULL - 1'b1;
    localparam logic [RCW-1:0] RX_FULL = {1'b1, {RX_LOG{1'b0}}};

    logic [7:0]        ram    [2**RAM_AW];
    logic [7:0]        tx_mem [2**TX_LOG];
    logic [7:0]        rx_mem [2**RX_LOG];

    logic [TX_LOG-1:0] tx_wp, tx_rp;
    logic [TCW-1:0]    tx_count, tx_count_next;
    logic [RX_LOG-1:0] rx_wp, rx_rp;
    logic [RCW-1:0]    rx_count;
    logic [31:0]       cyc_cnt, snapshot;

    logic              is_io;
    logic [2:0]        offset;
    logic [RAM_AW-1:0] ram_addr;
    logic              bus_rd, bus_wr;
    logic              stop_wr, tx_req, tx_full, tx_push, tx_pop;
    logic [7:0]        tx_push_data;
    logic              rx_push, rx_pop, rx_empty;
    logic [7:0]        rd_data;
    logic              unused_addr_bits;

    // Upper address bits are don't-care for both RAM and I/O decode.
    assign unused_addr_bits = ^bus.mem_a[31:18];

    assign is_io    = (bus.mem_a[17:16] == 2'b11);
    assign offset   = bus.mem_a[2:0];
    assign ram_addr = bus.mem_a[RAM_AW-1:0];
    assign bus_rd   = rdy_in & ~bus.mem_wr;
    assign bus_wr   = rdy_in &  bus.mem_wr;

    // Only the first stop write pushes the 0x00 terminator; once stopped, TX is closed.
    assign stop_wr      = bus_wr & is_io & (offset == 3'd4) & ~program_stop;
    assign tx_req       = (bus_wr & is_io & (offset == 3'd0) & (bus.mem_dout != 8'h00)
                           & ~program_stop) | stop_wr;
    assign tx_push_data = stop_wr ? 8'h00 : bus.mem_dout;
    assign tx_full      = (tx_count == TX_FULL);
    assign tx_pop       = tx_valid & tx_ready;
    assign tx_push      = tx_req & ~tx_full;
    assign tx_count_next = tx_count + TCW'(tx_push) - TCW'(tx_pop);

    assign tx_valid = (tx_count != '0);
    assign tx_data  = tx_valid ? tx_mem[tx_rp] : 8'h00;

    assign rx_empty = (rx_count == '0);
    assign rx_ready = (rx_count != RX_FULL);
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = bus_rd & is_io & (offset == 3'd0) & ~rx_empty;

    // Read data selected this cycle, registered onto mem_din at the edge.
    always_comb begin
        rd_data = 8'h00;
        if (is_io) begin
            case (offset)
                3'd0:    rd_data = rx_empty ? 8'h00 : rx_mem[rx_rp];
                3'd4:    rd_data = cyc_cnt[7:0];
                3'd5:    rd_data = snapshot[15:8];
                3'd6:    rd_data = snapshot[23:16];
                3'd7:    rd_data = snapshot[31:24];
                default: rd_data = 8'h00;
            endcase
        end else begin
            rd_data = ram[ram_addr];
        end
    end

    // RAM contents survive reset; writes are blocked while reset is asserted.
    always_ff @(posedge clk_in) begin
        if (rst_in && bus_wr && !is_io) begin
            ram[ram_addr] <= bus.mem_dout;
        end
    end

    // FIFO storage needs no reset; the pointers and counts define what is valid.
    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wp] <= tx_push_data;
        end
        if (rx_push) begin
            rx_mem[rx_wp] <= rx_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            tx_wp              <= '0;
            tx_rp              <= '0;
            tx_count           <= '0;
            tx_overflow        <= 1'b0;
            bus.io_buffer_full <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_wp <= tx_wp + 1'b1;
            end
            if (tx_pop) begin
                tx_rp <= tx_rp + 1'b1;
            end
            tx_count <= tx_count_next;
            if (tx_req && tx_full) begin
                tx_overflow <= 1'b1;
            end
            // One slot of margin: a write issued while the flag is rising still fits.
            bus.io_buffer_full <= (tx_count_next >= TX_NEAR);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                rx_wp <= rx_wp + 1'b1;
            end
            if (rx_pop) begin
                rx_rp <= rx_rp + 1'b1;
            end
            rx_count <= rx_count + RCW'(rx_push) - RCW'(rx_pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bus.mem_din  <= 8'h00;
            cyc_cnt      <= 32'd0;
            snapshot     <= 32'd0;
            program_stop <= 1'b0;
        end else begin
            if (rdy_in) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (bus_rd) begin
                bus.mem_din <= rd_data;
            end
            // Reading the low counter byte freezes the full value for the 0x30005..7 reads.
            if (bus_rd && is_io && (offset == 3'd4)) begin
                snapshot <= cyc_cnt;
            end
            if (stop_wr) begin
                program_stop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios plus a randomized
// phase, all compared against a queue-based reference model of the memory/IO target.
module tb_mem_io_responder;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       rdy_in;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       program_stop;
    logic       tx_overflow;

    mem_io_responder_if bus ();

    mem_io_responder dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .bus          (bus.slave),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .program_stop (program_stop),
        .tx_overflow  (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [7:0]  ram_m [int];
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    logic [31:0] cyc_m;
    logic [31:0] snap_m;
    logic [7:0]  din_m;
    bit          din_known;
    bit          stop_m;
    bit          ovf_m;
    bit          full_m;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic txPush(input logic [7:0] data, input int pre_count);
        if (pre_count == 16) ovf_m = 1'b1;
        else tx_q.push_back(data);
    endtask

    // Applies the rules of one clock edge to the model, using the inputs seen at that edge.
    task automatic modelEdge();
        int         tx_n;
        int         rx_n;
        bit         io;
        logic [2:0] off;
        int         ra;
        if (!rst_in) begin
            tx_q.delete();
            rx_q.delete();
            din_m = 8'h00;
            din_known = 1'b1;
            cyc_m = 32'd0;
            snap_m = 32'd0;
            stop_m = 1'b0;
            ovf_m = 1'b0;
            full_m = 1'b0;
            return;
        end
        tx_n = tx_q.size();
        rx_n = rx_q.size();
        io   = (bus.mem_a[17:16] == 2'b11);
        off  = bus.mem_a[2:0];
        ra   = int'(bus.mem_a[16:0]);
        if (tx_n > 0 && tx_ready) void'(tx_q.pop_front());
        if (rdy_in) begin
            if (bus.mem_wr) begin
                if (!io) ram_m[ra] = bus.mem_dout;
                else if (off == 3'd0 && bus.mem_dout != 8'h00 && !stop_m) txPush(bus.mem_dout, tx_n);
                else if (off == 3'd4 && !stop_m) begin
                    stop_m = 1'b1;
                    txPush(8'h00, tx_n);
                end
            end else begin
                din_known = 1'b1;
                if (!io) begin
                    if (ram_m.exists(ra)) din_m = ram_m[ra];
                    else din_known = 1'b0;
                end else begin
                    case (off)
                        3'd0: din_m = (rx_n > 0) ? rx_q.pop_front() : 8'h00;
                        3'd4: begin
                            din_m  = cyc_m[7:0];
                            snap_m = cyc_m;
                        end
                        3'd5: din_m = snap_m[15:8];
                        3'd6: din_m = snap_m[23:16];
                        3'd7: din_m = snap_m[31:24];
                        default: din_m = 8'h00;
                    endcase
                end
            end
            cyc_m = cyc_m + 32'd1;
        end
        if (rx_valid && rx_n < 16) rx_q.push_back(rx_data);
        full_m = (tx_q.size() >= 15);
    endtask

    task automatic clockCycle();
        @(posedge clk_in);
        modelEdge();
        #1;
        if (din_known) checkOutput("mem_din", 32'(bus.mem_din), 32'(din_m));
        checkOutput("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
        checkOutput("tx_data", 32'(tx_data), (tx_q.size() != 0) ? 32'(tx_q[0]) : 32'd0);
        checkOutput("io_buffer_full", 32'(bus.io_buffer_full), 32'(full_m));
        checkOutput("rx_ready", 32'(rx_ready), 32'(rx_q.size() != 16));
        checkOutput("program_stop", 32'(program_stop), 32'(stop_m));
        checkOutput("tx_overflow", 32'(tx_overflow), 32'(ovf_m));
    endtask

    task automatic applyStimulus(input logic rdy, input logic [31:0] addr, input logic wr,
                                 input logic [7:0] dout);
        rdy_in       = rdy;
        bus.mem_a    = addr;
        bus.mem_wr   = wr;
        bus.mem_dout = dout;
        clockCycle();
    endtask

    function automatic logic [31:0] ramAddr(input int k);
        logic [31:0] base;
        base = (k < 32) ? 32'(k) : 32'h1FFF0 + 32'(k - 32);
        return base | ($urandom() & 32'hFFFC0000);
    endfunction

    initial begin
        logic [31:0] pre;
        logic [31:0] addr;
        logic [2:0]  off;
        logic        wr;
        logic [7:0]  dout;

        rst_in = 1'b0;
        rdy_in = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        bus.mem_a = 32'd0;
        bus.mem_wr = 1'b0;
        bus.mem_dout = 8'h00;
        din_known = 1'b0;

        // Reset state
        clockCycle();
        clockCycle();
        checkOutput("reset_mem_din", 32'(bus.mem_din), 32'h00);
        checkOutput("reset_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("reset_rx_ready", 32'(rx_ready), 32'd1);
        rst_in = 1'b1;

        // T1: RAM write then read, one-cycle latency
        applyStimulus(1'b1, 32'h10, 1'b1, 8'hA5);
        applyStimulus(1'b1, 32'h10, 1'b0, 8'h00);
        checkOutput("t1_read", 32'(bus.mem_din), 32'hA5);

        // T2: 'H','i',0x00 -> only two bytes queued, then drained in order
        applyStimulus(1'b1, 32'h30000, 1'b1, 8'h48);
        applyStimulus(1'b1, 32'h30000, 1'b1, 8'h69);
        applyStimulus(1'b1, 32'h30000, 1'b1, 8'h00);
        checkOutput("t2_head", 32'(tx_data), 32'h48);
        checkOutput("t2_count", tx_q.size(), 32'd2);
        tx_ready = 1'b1;
        applyStimulus(1'b1, 32'h10, 1'b0, 8'h00);
        checkOutput("t2_second", 32'(tx_data), 32'h69);
        applyStimulus(1'b1, 32'h10, 1'b0, 8'h00);
        checkOutput("t2_empty", 32'(tx_valid), 32'd0);

        // T3: fill the TX FIFO, nearly-full flag and overflow
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 32'h30000, 1'b1, 8'(8'h41 + i));
            if (i == 13) checkOutput("t3_not_full_14", 32'(bus.io_buffer_full), 32'd0);
            if (i == 14) checkOutput("t3_full_15", 32'(bus.io_buffer_full), 32'd1);
            if (i == 15) checkOutput("t3_no_ovf_16", 32'(tx_overflow), 32'd0);
        end
        checkOutput("t3_ovf_17", 32'(tx_overflow), 32'd1);
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h10, 1'b0, 8'h00);

        // T4: RX push two bytes, read three times
        rx_valid = 1'b1;
        rx_data = 8'h31;
        applyStimulus(1'b1, 32'h10, 1'b0, 8'h00);
        rx_data = 8'h32;
        applyStimulus(1'b1, 32'h10, 1'b0, 8'h00);
        rx_valid = 1'b0;
        applyStimulus(1'b1, 32'h30000, 1'b0, 8'h00);
        checkOutput("t4_rx0", 32'(bus.mem_din), 32'h31);
        applyStimulus(1'b1, 32'h30000, 1'b0, 8'h00);
        checkOutput("t4_rx1", 32'(bus.mem_din), 32'h32);
        applyStimulus(1'b1, 32'h30000, 1'b0, 8'h00);
        checkOutput("t4_rx_empty", 32'(bus.mem_din), 32'h00);
        checkOutput("t4_rx_ready", 32'(rx_ready), 32'd1);

        // T5: cycle counter snapshot and freeze
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 32'h10, 1'b0, 8'h00);
        pre = cyc_m;
        applyStimulus(1'b1, 32'h30004, 1'b0, 8'h00);
        checkOutput("t5_byte0", 32'(bus.mem_din), 32'(pre[7:0]));
        applyStimulus(1'b1, 32'h30005, 1'b0, 8'h00);
        checkOutput("t5_byte1", 32'(bus.mem_din), 32'(pre[15:8]));
        applyStimulus(1'b1, 32'h30006, 1'b0, 8'h00);
        checkOutput("t5_byte2", 32'(bus.mem_din), 32'(pre[23:16]));
        applyStimulus(1'b1, 32'h30007, 1'b0, 8'h00);
        checkOutput("t5_byte3", 32'(bus.mem_din), 32'(pre[31:24]));
        pre = cyc_m;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h30000, 1'b1, 8'h55);
        applyStimulus(1'b1, 32'h30004, 1'b0, 8'h00);
        checkOutput("t5_frozen", 32'(bus.mem_din), 32'(pre[7:0]));

        // Randomized phase against the model
        for (int k = 0; k < 48; k++) applyStimulus(1'b1, ramAddr(k), 1'b1, 8'($urandom()));
        for (int i = 0; i < 1500; i++) begin
            tx_ready = (i < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom());
            wr       = 1'($urandom_range(0, 1));
            dout     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom());
            if ($urandom_range(0, 3) < 2) begin
                addr = ramAddr($urandom_range(0, 47));
            end else begin
                off = 3'($urandom_range(0, 7));
                if (wr && off == 3'd4) off = 3'd0;
                addr = 32'h30000 | 32'(off) | ($urandom() & 32'hFFFCFFF8);
            end
            applyStimulus(1'($urandom_range(0, 9) != 0), addr, wr, dout);
        end

        // T6: program stop, terminator, later writes ignored, reset mid-drain
        tx_ready = 1'b1;
        rx_valid = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h10, 1'b0, 8'h00);
        tx_ready = 1'b0;
        applyStimulus(1'b1, 32'h30004, 1'b1, 8'h77);
        checkOutput("t6_stop", 32'(program_stop), 32'd1);
        checkOutput("t6_term_valid", 32'(tx_valid), 32'd1);
        checkOutput("t6_term_data", 32'(tx_data), 32'h00);
        applyStimulus(1'b1, 32'h30000, 1'b1, 8'h5A);
        applyStimulus(1'b1, 32'h30004, 1'b1, 8'h00);
        checkOutput("t6_single_term", tx_q.size(), 32'd1);
        rx_valid = 1'b1;
        rx_data = 8'h99;
        applyStimulus(1'b1, 32'h10, 1'b0, 8'h00);
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        rst_in = 1'b0;
        applyStimulus(1'b1, 32'h10, 1'b0, 8'h00);
        checkOutput("t6_rst_mem_din", 32'(bus.mem_din), 32'h00);
        checkOutput("t6_rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("t6_rst_tx_data", 32'(tx_data), 32'h00);
        checkOutput("t6_rst_stop", 32'(program_stop), 32'd0);
        checkOutput("t6_rst_ovf", 32'(tx_overflow), 32'd0);
        checkOutput("t6_rst_full", 32'(bus.io_buffer_full), 32'd0);
        rst_in = 1'b1;
        applyStimulus(1'b1, 32'h30000, 1'b0, 8'h00);
        checkOutput("t6_rx_cleared", 32'(bus.mem_din), 32'h00);
        applyStimulus(1'b1, 32'h30004, 1'b0, 8'h00);
        checkOutput("t6_cyc_restart", 32'(bus.mem_din), 32'h01);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
